conv_job_ctrl: RTL and testbench

- Job-level controller sitting between the system stream/config side and multi_dataflow (conv_mdc datapath).
- Accepts one frame job (width, height), drives the datapath's width/height parameters and meters exactly width*height input words into it.
- Forwards width*height output words downstream and signals done or err per job.
- Handles abort and drain timeout by pulsing a datapath reset.

---
 rtl/conv_job_ctrl_pkg.sv | 16 +
 rtl/conv_job_cnt.sv | 35 +++
 rtl/conv_job_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_conv_job_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_job_ctrl_pkg.sv
// Shared types and widths for the conv_mdc job controller.
package conv_job_ctrl_pkg;

   localparam int DIM_W_DEF = 16;
   localparam int CNT_W     = 2 * DIM_W_DEF;
   localparam int STREAM_W  = 32;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FEED    = 3'd1,
      ST_DRAIN   = 3'd2,
      ST_RECOVER = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

endpackage

// File: rtl/conv_job_cnt.sv
// Loadable up-counter with terminal compare on the current and the next value.
module conv_job_cnt
   import conv_job_ctrl_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         i_clock,
   input  logic         i_reset,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_inc,
   input  logic [W-1:0] i_term,
   output logic         o_tc,
   output logic         o_tc_inc
);

   logic [W-1:0] r_cnt;
   logic [W-1:0] w_cnt_inc;

   assign w_cnt_inc = r_cnt + W'(1);

   always_ff @(posedge i_clock) begin
      if (i_reset)
         r_cnt <= '0;
      else if (i_load)
         r_cnt <= i_load_val;
      else if (i_inc)
         r_cnt <= w_cnt_inc;
   end

   // o_tc_inc lets the caller act on the cycle that makes the count terminal
   assign o_tc     = (r_cnt == i_term);
   assign o_tc_inc = (w_cnt_inc == i_term);

endmodule

// File: rtl/conv_job_ctrl.sv
// Frame job controller in front of multi_dataflow: meters width*height words in and out.
// Optional cycle counter output o_perf_cycles when CONV_JOB_CTRL_PERF_EN is defined.
//
// state   | meaning
// IDLE    | waiting for a job, job_ready high
// FEED    | passing input words to the datapath, forwarding outputs
// DRAIN   | all inputs sent, waiting for remaining outputs (idle timeout armed)
// RECOVER | datapath held in reset after abort or timeout
// DONE    | one-cycle done pulse, err qualifies it
module conv_job_ctrl
   import conv_job_ctrl_pkg::*;
#(
   parameter int DIM_W      = DIM_W_DEF,
   parameter int TIMEOUT    = 4096,
   parameter int DF_RST_CYC = 4
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_job_valid,
   output logic                o_job_ready,
   input  logic [DIM_W-1:0]    i_job_width,
   input  logic [DIM_W-1:0]    i_job_height,
   input  logic                i_abort,
   input  logic [STREAM_W-1:0] i_src_data,
   input  logic                i_src_valid,
   output logic                o_src_ready,
   output logic [STREAM_W-1:0] o_df_in_data,
   output logic                o_df_in_wr,
   input  logic                i_df_in_full,
   input  logic [STREAM_W-1:0] i_df_out_data,
   input  logic                i_df_out_wr,
   output logic                o_df_out_full,
   output logic [STREAM_W-1:0] o_dst_data,
   output logic                o_dst_valid,
   input  logic                i_dst_ready,
   output logic [31:0]         o_width,
   output logic [31:0]         o_height,
   output logic                o_df_reset,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_err
`ifdef CONV_JOB_CTRL_PERF_EN
  ,output logic [31:0]         o_perf_cycles
`endif
);

   localparam int CW = 2 * DIM_W;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_total;
   logic [CW-1:0] w_job_total;
   logic [CW-1:0] w_tmr_term;
   logic [31:0]   r_width;
   logic [31:0]   r_height;
   logic          r_live;
   logic          r_err;
   logic          r_df_reset;
   logic          w_accept;
   logic          w_xfer_state;
   logic          w_in_xfer;
   logic          w_out_xfer;
   logic          w_out_drop;
   logic          w_out_complete;
   logic          w_in_tc;
   logic          w_in_tc_inc;
   logic          w_out_tc;
   logic          w_out_tc_inc;
   logic          w_tmr_tc;
   logic          w_tmr_tc_inc;
   logic          w_tmr_load;
   logic          w_tmr_inc;
   logic          w_abort;

   assign w_job_total    = CW'(i_job_width) * CW'(i_job_height);
   assign w_accept       = i_job_valid && o_job_ready;
   assign w_abort        = i_abort && (r_state != ST_IDLE);
   assign w_xfer_state   = (r_state == ST_FEED) || (r_state == ST_DRAIN);
   assign w_in_xfer      = o_df_in_wr;
   // once the frame is complete any further datapath word is swallowed
   assign w_out_drop     = w_xfer_state && w_out_tc && i_df_out_wr;
   assign w_out_xfer     = w_xfer_state && !w_out_tc && i_df_out_wr && i_dst_ready;
   assign w_out_complete = w_out_tc || (w_out_xfer && w_out_tc_inc);

   // the timer doubles as the DRAIN idle watchdog and the RECOVER hold counter
   assign w_tmr_term = (r_state == ST_RECOVER) ? CW'(DF_RST_CYC) : CW'(TIMEOUT);
   assign w_tmr_load = (w_state_nxt != r_state) || w_abort ||
                       ((r_state == ST_DRAIN) && i_df_out_wr);
   assign w_tmr_inc  = (r_state == ST_DRAIN) || (r_state == ST_RECOVER);

   conv_job_cnt #(.W(CW)) u_in_cnt (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_load     (w_accept),
      .i_load_val ('0),
      .i_inc      (w_in_xfer),
      .i_term     (r_total),
      .o_tc       (w_in_tc),
      .o_tc_inc   (w_in_tc_inc)
   );

   conv_job_cnt #(.W(CW)) u_out_cnt (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_load     (w_accept),
      .i_load_val ('0),
      .i_inc      (w_out_xfer),
      .i_term     (r_total),
      .o_tc       (w_out_tc),
      .o_tc_inc   (w_out_tc_inc)
   );

   conv_job_cnt #(.W(CW)) u_tmr_cnt (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_load     (w_tmr_load),
      .i_load_val ('0),
      .i_inc      (w_tmr_inc),
      .i_term     (w_tmr_term),
      .o_tc       (w_tmr_tc),
      .o_tc_inc   (w_tmr_tc_inc)
   );

   always_ff @(posedge i_clock) begin
      if (i_reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:
            if (w_accept)
               w_state_nxt = (w_job_total == '0) ? ST_DONE : ST_FEED;
         ST_FEED:
            if (w_in_xfer && w_in_tc_inc)
               w_state_nxt = w_out_complete ? ST_DONE : ST_DRAIN;
         ST_DRAIN:
            if (w_out_xfer && w_out_tc_inc)
               w_state_nxt = ST_DONE;
            else if (!i_df_out_wr && (w_tmr_tc_inc || w_tmr_tc))
               w_state_nxt = ST_RECOVER;
         ST_RECOVER:
            if (w_tmr_tc_inc || w_tmr_tc)
               w_state_nxt = ST_DONE;
         ST_DONE:
            w_state_nxt = ST_IDLE;
         default:
            w_state_nxt = ST_IDLE;
      endcase
      if (w_abort)
         w_state_nxt = ST_RECOVER;
   end

   always_comb begin
      o_src_ready   = 1'b0;
      o_df_out_full = 1'b1;
      o_dst_valid   = 1'b0;
      if (r_state == ST_FEED)
         o_src_ready = !i_df_in_full && !w_in_tc;
      if (w_xfer_state) begin
         if (w_out_tc) begin
            o_df_out_full = 1'b0;
            o_dst_valid   = 1'b0;
         end else begin
            o_df_out_full = !i_dst_ready;
            o_dst_valid   = i_df_out_wr;
         end
      end
      o_df_in_wr = i_src_valid && o_src_ready;
   end

   assign o_df_in_data = i_src_data;
   assign o_dst_data   = i_df_out_data;
   assign o_job_ready  = (r_state == ST_IDLE) && r_live;
   assign o_busy       = (r_state != ST_IDLE);
   assign o_done       = (r_state == ST_DONE);
   assign o_err        = r_err;
   assign o_df_reset   = r_df_reset;
   assign o_width      = r_width;
   assign o_height     = r_height;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_live     <= 1'b0;
         r_total    <= '0;
         r_width    <= '0;
         r_height   <= '0;
         r_err      <= 1'b0;
         r_df_reset <= 1'b1;
      end else begin
         r_live     <= 1'b1;
         r_df_reset <= (w_state_nxt == ST_RECOVER);
         if (w_accept) begin
            r_total  <= w_job_total;
            r_width  <= 32'(i_job_width);
            r_height <= 32'(i_job_height);
            r_err    <= (w_job_total == '0);
         end else if ((w_state_nxt == ST_RECOVER) || w_out_drop) begin
            r_err    <= 1'b1;
         end
      end
   end

`ifdef CONV_JOB_CTRL_PERF_EN
   logic [31:0] r_perf;

   always_ff @(posedge i_clock) begin
      if (i_reset)
         r_perf <= '0;
      else if (w_accept)
         r_perf <= '0;
      else if ((r_state != ST_IDLE) && (r_state != ST_DONE) && (r_perf != 32'hFFFF_FFFF))
         r_perf <= r_perf + 32'd1;
   end

   assign o_perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_conv_job_ctrl.sv
// Self-checking bench for conv_job_ctrl: randomized stream data and backpressure against a queue model.
module tb_conv_job_ctrl;

   localparam int TIMEOUT    = 16;
   localparam int DF_RST_CYC = 4;
   localparam int BIG        = 1000000;

   logic        clk = 1'b0;
   logic        reset;
   logic        job_valid;
   logic        job_ready;
   logic [15:0] job_width;
   logic [15:0] job_height;
   logic        abort;
   logic [31:0] src_data;
   logic        src_valid;
   logic        src_ready;
   logic [31:0] df_in_data;
   logic        df_in_wr;
   logic        df_in_full;
   logic [31:0] df_out_data;
   logic        df_out_wr;
   logic        df_out_full;
   logic [31:0] dst_data;
   logic        dst_valid;
   logic        dst_ready;
   logic [31:0] width;
   logic [31:0] height;
   logic        df_reset;
   logic        busy;
   logic        done;
   logic        err;
`ifdef CONV_JOB_CTRL_PERF_EN
   logic [31:0] perf_cycles;
   logic [31:0] done_perf;
`endif

   always #5 clk = ~clk;

   conv_job_ctrl #(.DIM_W(16), .TIMEOUT(TIMEOUT), .DF_RST_CYC(DF_RST_CYC)) dut (
      .i_clock       (clk),
      .i_reset       (reset),
      .i_job_valid   (job_valid),
      .o_job_ready   (job_ready),
      .i_job_width   (job_width),
      .i_job_height  (job_height),
      .i_abort       (abort),
      .i_src_data    (src_data),
      .i_src_valid   (src_valid),
      .o_src_ready   (src_ready),
      .o_df_in_data  (df_in_data),
      .o_df_in_wr    (df_in_wr),
      .i_df_in_full  (df_in_full),
      .i_df_out_data (df_out_data),
      .i_df_out_wr   (df_out_wr),
      .o_df_out_full (df_out_full),
      .o_dst_data    (dst_data),
      .o_dst_valid   (dst_valid),
      .i_dst_ready   (dst_ready),
      .o_width       (width),
      .o_height      (height),
      .o_df_reset    (df_reset),
      .o_busy        (busy),
      .o_done        (done),
      .o_err         (err)
`ifdef CONV_JOB_CTRL_PERF_EN
     ,.o_perf_cycles (perf_cycles)
`endif
   );

   int n_vec = 0;
   int n_bad = 0;

   logic [31:0] src_q[$];
   logic [31:0] dp_q[$];
   logic [31:0] exp_q[$];

   int full_mode, rdy_pct, dp_limit, dp_emitted;
   int tick_no;
   int in_cnt, dst_cnt, rst_cnt, done_cnt, src_rdy_cnt;
   int last_dst_tick, last_in_tick, first_rst_tick, last_rst_tick, done_tick, accept_tick;
   logic accepted, done_err;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_vec++;
      assert (obs === expv)
      else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // one clock: drive models at negedge, observe just before posedge, return just after it
   task automatic tick();
      @(negedge clk);
      tick_no++;
      src_valid   = (src_q.size() > 0);
      src_data    = src_valid ? src_q[0] : 32'hDEAD_BEEF;
      df_in_full  = (full_mode != 0) && (tick_no % 2 == 1);
      dst_ready   = ($urandom_range(99) < rdy_pct);
      df_out_wr   = (dp_q.size() > 0) && (dp_emitted < dp_limit);
      df_out_data = df_out_wr ? dp_q[0] : 32'h0;
      #1;
      if (job_valid && job_ready) begin
         accepted    = 1'b1;
         accept_tick = tick_no;
      end
      if (src_ready) src_rdy_cnt++;
      if (df_in_wr) begin
         dp_q.push_back(src_q.pop_front());
         in_cnt++;
         last_in_tick = tick_no;
      end
      if (dst_valid && dst_ready) begin
         dst_cnt++;
         last_dst_tick = tick_no;
         n_vec++;
         assert (exp_q.size() > 0)
         else begin
            n_bad++;
            $error("FAIL dst_extra observed_count=%0d expected_none", dst_cnt);
         end
         if (exp_q.size() > 0) chk("dst_word", dst_data, exp_q.pop_front());
      end
      if (df_out_wr && !df_out_full) begin
         void'(dp_q.pop_front());
         dp_emitted++;
      end
      if (df_reset) begin
         rst_cnt++;
         if (first_rst_tick < 0) first_rst_tick = tick_no;
         last_rst_tick = tick_no;
         dp_q.delete();
      end
      if (done) begin
         done_cnt++;
         done_tick = tick_no;
         done_err  = err;
`ifdef CONV_JOB_CTRL_PERF_EN
         done_perf = perf_cycles;
`endif
      end
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input int w, input int h, input int fm, input int pct, input int lim);
      int n;
      int guard;
      n = w * h;
      src_q.delete(); dp_q.delete(); exp_q.delete();
      for (int i = 0; i < n + 4; i++) src_q.push_back($urandom);
      for (int i = 0; i < n && i < lim; i++) exp_q.push_back(src_q[i]);
      full_mode = fm; rdy_pct = pct; dp_limit = lim; dp_emitted = 0;
      in_cnt = 0; dst_cnt = 0; rst_cnt = 0; done_cnt = 0; src_rdy_cnt = 0;
      last_dst_tick = -1; last_in_tick = -1; first_rst_tick = -1; last_rst_tick = -1;
      done_tick = -1; accept_tick = -1; accepted = 1'b0; done_err = 1'b0;
      job_width = 16'(w); job_height = 16'(h); job_valid = 1'b1;
      guard = 0;
      while (!accepted && guard < 20) begin
         tick();
         guard++;
      end
      job_valid = 1'b0;
      chk("job_accept", accepted, 1'b1);
   endtask

   task automatic run_job(input int w, input int h, input int fm, input int pct,
                          input int lim, input int abort_at);
      int n, guard, ref_tick;
      logic aborted, exp_err;
      n = w * h;
      start_job(w, h, fm, pct, lim);
      aborted = 1'b0;
      guard = 0;
      while (done_cnt == 0 && guard < 3000) begin
         if (abort_at >= 0 && !aborted && in_cnt >= abort_at) begin
            abort = 1'b1;
            aborted = 1'b1;
         end else begin
            abort = 1'b0;
         end
         tick();
         guard++;
      end
      abort = 1'b0;
      exp_err = (n == 0) || (abort_at >= 0) || (lim < n);
      chk("done_seen", done_cnt, 1);
      chk("err_at_done", done_err, exp_err);
      chk("width_held", width, w);
      chk("height_held", height, h);
      if (n == 0) begin
         chk("zero_no_src_ready", src_rdy_cnt, 0);
         chk("zero_done_latency_le2", (done_tick - accept_tick) <= 2, 1'b1);
      end else if (abort_at >= 0) begin
         chk("abort_in_bound", in_cnt <= abort_at + 1, 1'b1);
         chk("abort_rst_cycles", rst_cnt, DF_RST_CYC);
         chk("abort_done_after_rst", done_tick - last_rst_tick, 1);
      end else if (lim < n) begin
         ref_tick = (last_dst_tick > last_in_tick) ? last_dst_tick : last_in_tick;
         chk("tmo_in_cnt", in_cnt, n);
         chk("tmo_dst_cnt", dst_cnt, lim);
         chk("tmo_idle_gap", first_rst_tick - ref_tick, TIMEOUT + 1);
         chk("tmo_rst_cycles", rst_cnt, DF_RST_CYC);
         chk("tmo_done_after_rst", done_tick - last_rst_tick, 1);
      end else begin
         chk("in_cnt", in_cnt, n);
         chk("src_ready_cnt", src_rdy_cnt, n);
         chk("dst_cnt", dst_cnt, n);
         chk("done_latency", done_tick - last_dst_tick, 1);
         chk("no_df_reset", rst_cnt, 0);
`ifdef CONV_JOB_CTRL_PERF_EN
         chk("perf_cycles", done_perf, done_tick - accept_tick - 1);
`endif
      end
      tick();
      chk("post_done_low", done, 1'b0);
      chk("post_busy_low", busy, 1'b0);
      chk("post_job_ready", job_ready, 1'b1);
   endtask

   initial begin
      int guard;
      tick_no = 0; full_mode = 0; rdy_pct = 100; dp_limit = BIG; dp_emitted = 0;
      reset = 1'b1; job_valid = 1'b0; job_width = '0; job_height = '0; abort = 1'b0;
      src_valid = 1'b0; src_data = '0; df_in_full = 1'b0;
      df_out_wr = 1'b0; df_out_data = '0; dst_ready = 1'b0;
      repeat (3) tick();
      chk("rst_job_ready", job_ready, 1'b0);
      chk("rst_width", width, 32'd0);
      chk("rst_height", height, 32'd0);
      chk("rst_df_reset", df_reset, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      reset = 1'b0;
      tick();
      chk("rel_job_ready", job_ready, 1'b1);
      chk("rel_df_reset", df_reset, 1'b0);

      run_job(4, 2, 0, 100, BIG, -1);
      run_job(3, 3, 1, 30, BIG, -1);
      run_job(0, 5, 0, 100, BIG, -1);
      run_job(8, 8, 0, 100, BIG, 20);
      run_job(2, 2, 0, 100, BIG, -1);
      run_job(2, 2, 0, 100, 3, -1);
      for (int j = 0; j < 3; j++)
         run_job($urandom_range(5, 1), $urandom_range(5, 1), $urandom_range(1, 0),
                 $urandom_range(100, 30), BIG, -1);

      start_job(8, 8, 0, 100, BIG);
      guard = 0;
      while (in_cnt < 5 && guard < 50) begin
         tick();
         guard++;
      end
      chk("mid_feed_reached", in_cnt >= 5, 1'b1);
      reset = 1'b1;
      tick();
      chk("mid_rst_job_ready", job_ready, 1'b0);
      chk("mid_rst_width", width, 32'd0);
      chk("mid_rst_height", height, 32'd0);
      chk("mid_rst_df_reset", df_reset, 1'b1);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_done", done, 1'b0);
      chk("mid_rst_err", err, 1'b0);
      chk("mid_rst_src_ready", src_ready, 1'b0);
      chk("mid_rst_dst_valid", dst_valid, 1'b0);
      chk("mid_rst_df_out_full", df_out_full, 1'b1);
      reset = 1'b0;
      tick();
      chk("mid_rel_job_ready", job_ready, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
